// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master.
// State encoding, byte width and counter sizing.
package spi_pkg;

  localparam int SPI_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    TRAIL,
    GAP
  } spi_state_t;

  function automatic int spi_cnt_w(input int d);
    return (d < 2) ? 1 : $clog2(d);
  endfunction

endpackage

// File: rtl/spi_sck_tick.sv
// SCK half-period divider: one-cycle tick every CLK_DIV cycles.
// Restarts from zero whenever the FSM changes state.
module spi_sck_tick
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  output logic o_tick,
  output logic o_pre,
  output logic o_zero
);

  localparam int CW = spi_cnt_w(CLK_DIV);

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == CW'(CLK_DIV - 1));
  assign o_pre  = (r_cnt == CW'(CLK_DIV - 2));
  assign o_zero = (r_cnt == '0);

  // count cycles within the current state, wrap on tick
  always_ff @(posedge clk) begin
    if (reset || i_clr || o_tick) r_cnt <= '0;
    else                          r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 byte SPI master, MSB first, active-low cs.
// Optional back-to-back bursts: SPI_MASTER_BURST_EN.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs
);

  localparam int GW = spi_cnt_w(CS_GAP);

  spi_state_t            r_state, w_next;
  logic [2:0]            r_bit;
  logic [GW-1:0]         r_gap;
  logic [SPI_BYTE_W-1:0] r_shift, r_rx;
  logic r_cs, r_sck, r_busy, r_done, r_mosi;
  logic w_cs, w_sck, w_busy, w_done, w_mosi;
  logic w_tick, w_pre, w_zero, w_clr;
  logic w_load, w_burst, w_gap_end;

`ifdef SPI_MASTER_BURST_EN
  assign w_burst = start;
`else
  assign w_burst = 1'b0;
`endif

  assign w_gap_end = (r_gap == GW'(CS_GAP - 1));
  assign w_clr     = (w_next != r_state);

  spi_sck_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_clr),
    .o_tick (w_tick),
    .o_pre  (w_pre),
    .o_zero (w_zero)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // next-state logic, phases advance on divider ticks
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (start)     w_next = SETUP;
      SETUP: if (w_tick)    w_next = HIGH;
      HIGH:  if (w_tick)    w_next = (r_bit == 3'd7) ? TRAIL : LOW;
      LOW:   if (w_tick)    w_next = HIGH;
      TRAIL: if (w_tick)    w_next = w_burst ? SETUP : GAP;
      GAP:   if (w_gap_end) w_next = IDLE;
      default:              w_next = IDLE;
    endcase
  end

  // next values of the registered outputs
  always_comb begin
    w_load = (w_next == SETUP) && (r_state != SETUP);
    w_cs   = !(w_next inside {SETUP, HIGH, LOW, TRAIL});
    w_sck  = (w_next == HIGH);
    w_busy = (w_next != IDLE);
    w_done = (r_state == TRAIL) && w_pre;
    w_mosi = r_mosi;
    if (w_load)
      w_mosi = tx_data[SPI_BYTE_W-1];
    else if (r_state == HIGH && w_next == LOW)
      w_mosi = r_shift[SPI_BYTE_W-1];
    else if (w_next == IDLE)
      w_mosi = 1'b0;
  end

  // output, shift and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cs    <= 1'b1;
      r_sck   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_mosi  <= 1'b0;
      r_rx    <= '0;
      r_shift <= '0;
      r_bit   <= '0;
      r_gap   <= '0;
    end else begin
      r_cs   <= w_cs;
      r_sck  <= w_sck;
      r_busy <= w_busy;
      r_done <= w_done;
      r_mosi <= w_mosi;
      if (w_load)
        r_shift <= tx_data;
      else if (r_state == HIGH && w_zero)
        r_shift <= {r_shift[SPI_BYTE_W-2:0], miso};
      if (w_done)
        r_rx <= r_shift;
      if (r_state == HIGH && w_tick)
        r_bit <= (r_bit == 3'd7) ? 3'd0 : r_bit + 3'd1;
      if (r_state == GAP && !w_gap_end)
        r_gap <= r_gap + 1'b1;
      else
        r_gap <= '0;
    end
  end

  assign cs      = r_cs;
  assign sck     = r_sck;
  assign busy    = r_busy;
  assign done    = r_done;
  assign mosi    = r_mosi;
  assign rx_data = r_rx;

endmodule
